// File: rtl/if_bpu_pkg.sv
// Shared definitions for the fetch-stage branch predictor: PC width and FSM encoding.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package if_bpu_pkg;
  // INIT sweeps the counter table, RUN predicts and trains.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpu_state_e;
endpackage

// File: rtl/bpu_sat_cnt.sv
// Saturating up/down counter next-value logic (pure combinational).
module bpu_sat_cnt #(
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] i_cnt,
  input  logic                 i_up,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Step toward the outcome, holding at either end of the range.
  always_comb begin
    o_cnt = i_cnt;
    if (i_up) begin
      if (i_cnt != CNT_MAX) o_cnt = i_cnt + CNT_WIDTH'(1);
    end else if (i_cnt != '0) begin
      o_cnt = i_cnt - CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/if_bpu.sv
// Fetch-stage branch predictor: bimodal counter table with static BTFN fallback,
// an INIT sweep after reset/flush, and resolved/mispredict statistics.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module if_bpu
  import if_bpu_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_WIDTH = 2,
  parameter int DYN_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [`PC_WIDTH-1:0] lk_pc_i,
  input  logic                 lk_branch_i,
  input  logic                 lk_imm_neg_i,
  output logic                 prdt_taken_o,
  input  logic                 upd_valid_i,
  input  logic [`PC_WIDTH-1:0] upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic                 upd_prdt_i,
  input  logic                 tbl_flush_i,
  output logic                 busy_o,
  output logic [31:0]          br_cnt_o,
  output logic [31:0]          mis_cnt_o
);
  localparam int                   IDX_W    = $clog2(BHT_DEPTH);
  localparam logic [CNT_WIDTH-1:0] INIT_VAL = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BHT_DEPTH - 1);

  logic [CNT_WIDTH-1:0] r_bht [BHT_DEPTH];
  bpu_state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_init_idx, w_init_idx_nxt;
  logic [31:0]          r_br_cnt, r_mis_cnt;

  logic [IDX_W-1:0]     w_lk_idx, w_upd_idx, w_widx;
  logic [CNT_WIDTH-1:0] w_upd_cnt, w_upd_cnt_nxt, w_wdata;
  logic                 w_we, w_dyn_prdt;

  // Word-aligned PCs: drop the two byte-offset bits, keep IDX_W index bits.
  assign w_lk_idx  = lk_pc_i[IDX_W+1:2];
  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_cnt = r_bht[w_upd_idx];

  wire w_unused_pc = ^{lk_pc_i[1:0], lk_pc_i[`PC_WIDTH-1:IDX_W+2],
                       upd_pc_i[1:0], upd_pc_i[`PC_WIDTH-1:IDX_W+2]};

  bpu_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sat_cnt (
    .i_cnt (w_upd_cnt),
    .i_up  (upd_taken_i),
    .o_cnt (w_upd_cnt_nxt)
  );

  // Next-state and table-write selection: the sweep owns the write port in INIT,
  // a flush in RUN wins over a same-cycle training update.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    w_we           = 1'b0;
    w_widx         = w_upd_idx;
    w_wdata        = w_upd_cnt_nxt;
    if (r_state == ST_INIT) begin
      w_we    = rst_n;
      w_widx  = r_init_idx;
      w_wdata = INIT_VAL;
      if (tbl_flush_i) begin
        w_init_idx_nxt = '0;
      end else if (r_init_idx == LAST_IDX) begin
        w_state_nxt    = ST_RUN;
        w_init_idx_nxt = '0;
      end else begin
        w_init_idx_nxt = r_init_idx + IDX_W'(1);
      end
    end else begin
      if (tbl_flush_i) begin
        w_state_nxt    = ST_INIT;
        w_init_idx_nxt = '0;
      end else begin
        w_we = rst_n & upd_valid_i;
      end
    end
  end

  // FSM state and sweep pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  // Counter table: no reset, contents are defined by the INIT sweep.
  always_ff @(posedge clk) begin
    if (w_we) r_bht[w_widx] <= w_wdata;
  end

  // Statistics: count every resolution, saturating, independent of table state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (upd_valid_i) begin
      if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + 32'd1;
      if ((upd_prdt_i != upd_taken_i) && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  generate
    if (DYN_EN != 0) begin : g_dyn
      assign w_dyn_prdt = (r_state == ST_RUN) ? r_bht[w_lk_idx][CNT_WIDTH-1] : lk_imm_neg_i;
    end else begin : g_static
      wire w_unused_lk = ^w_lk_idx;
      assign w_dyn_prdt = lk_imm_neg_i;
    end
  endgenerate

  assign prdt_taken_o = lk_branch_i & w_dyn_prdt;
  assign busy_o       = (r_state == ST_INIT);
  assign br_cnt_o     = r_br_cnt;
  assign mis_cnt_o    = r_mis_cnt;
endmodule

// File: tb/tb_if_bpu.sv
// Self-checking bench for if_bpu: directed scenarios plus randomized traffic
// against a behavioural model (counter array + remaining-busy-cycles count).
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module tb_if_bpu;
  localparam int DEPTH = 64;
  localparam int PCW   = `PC_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [PCW-1:0] lk_pc, upd_pc;
  logic           lk_br, lk_neg, upd_valid, upd_taken, upd_prdt, flush;
  logic           prdt, busy, prdt_s, busy_s;
  logic [31:0]    br_cnt, mis_cnt, br_s, mis_s;

  if_bpu #(.BHT_DEPTH(DEPTH), .CNT_WIDTH(2), .DYN_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .lk_pc_i(lk_pc), .lk_branch_i(lk_br), .lk_imm_neg_i(lk_neg),
    .prdt_taken_o(prdt), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_prdt_i(upd_prdt), .tbl_flush_i(flush), .busy_o(busy), .br_cnt_o(br_cnt), .mis_cnt_o(mis_cnt));

  if_bpu #(.BHT_DEPTH(DEPTH), .CNT_WIDTH(2), .DYN_EN(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .lk_pc_i(lk_pc), .lk_branch_i(lk_br), .lk_imm_neg_i(lk_neg),
    .prdt_taken_o(prdt_s), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_prdt_i(upd_prdt), .tbl_flush_i(flush), .busy_o(busy_s), .br_cnt_o(br_s), .mis_cnt_o(mis_s));

  int checks = 0;
  int errors = 0;

  // Reference model: counter values per slot, cycles of initialisation left, stats.
  int          mtab [DEPTH];
  int          busy_left;
  logic [31:0] m_br, m_mis;

  function automatic int idx_of(input logic [PCW-1:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic m_pred(input logic [PCW-1:0] pc, input logic br, input logic neg);
    if (!br) return 1'b0;
    if (busy_left > 0) return neg;
    return (mtab[idx_of(pc)] >= 2);
  endfunction

  task automatic model_edge();
    int k;
    if (!rst_n) begin
      busy_left = DEPTH;
      m_br = '0;
      m_mis = '0;
      return;
    end
    if (upd_valid) begin
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (upd_prdt != upd_taken && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    end
    if (flush) begin
      busy_left = DEPTH;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) foreach (mtab[i]) mtab[i] = 1;
    end else if (upd_valid) begin
      k = idx_of(upd_pc);
      if (upd_taken) mtab[k] = (mtab[k] < 3) ? mtab[k] + 1 : 3;
      else           mtab[k] = (mtab[k] > 0) ? mtab[k] - 1 : 0;
    end
  endtask

  // Inputs change at negedge; one call advances exactly one rising edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; lk_pc = '0; upd_pc = '0; lk_br = 1'b0; lk_neg = 1'b0;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_prdt = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++; if (br_cnt !== 32'd0) begin errors++; $display("FAIL reset_br got %0d want 0", br_cnt); end
    checks++; if (mis_cnt !== 32'd0) begin errors++; $display("FAIL reset_mis got %0d want 0", mis_cnt); end
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      lk_br = (c == 10 || c == 11);
      lk_neg = (c == 10);
      lk_pc = 32'h40;
      #1;
      if (c == 10) begin
        checks++; if (prdt !== 1'b1) begin errors++; $display("FAIL static_backward got %b want 1", prdt); end
      end
      if (c == 11) begin
        checks++; if (prdt !== 1'b0) begin errors++; $display("FAIL static_forward got %b want 0", prdt); end
      end
      if (busy !== 1'b1) break;
      n++;
      tick();
    end
    lk_br = 1'b0;
    checks++; if (n != DEPTH) begin errors++; $display("FAIL busy_len got %0d want %0d", n, DEPTH); end
  endtask

  task automatic train(input logic [PCW-1:0] pc, input logic taken, input int times);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_prdt = taken;
    for (int i = 0; i < times; i++) tick();
    upd_valid = 1'b0;
  endtask

  task automatic test_dyn_basic();
    lk_pc = 32'h100; lk_br = 1'b1; lk_neg = 1'b1;
    #1;
    checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL init_pred got %b want %b", prdt, m_pred(lk_pc, lk_br, lk_neg)); end
    train(32'h100, 1'b1, 2);
    #1;
    checks++; if (dut.r_bht[0] !== 2'(mtab[0])) begin errors++; $display("FAIL cnt_after_taken got %0d want %0d", dut.r_bht[0], mtab[0]); end
    checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL pred_after_taken got %b want %b", prdt, m_pred(lk_pc, lk_br, lk_neg)); end
    train(32'h100, 1'b0, 4);
    #1;
    checks++; if (dut.r_bht[0] !== 2'(mtab[0])) begin errors++; $display("FAIL cnt_underflow got %0d want %0d", dut.r_bht[0], mtab[0]); end
    checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL pred_after_nt got %b want %b", prdt, m_pred(lk_pc, lk_br, lk_neg)); end
    train(32'h100, 1'b1, 1);
    #1;
    checks++; if (dut.r_bht[0] !== 2'(mtab[0])) begin errors++; $display("FAIL cnt_one got %0d want %0d", dut.r_bht[0], mtab[0]); end
  endtask

  task automatic test_same_cycle();
    lk_pc = 32'h100; lk_br = 1'b1; lk_neg = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_prdt = 1'b0;
    #1;
    checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL same_cycle_old got %b want %b", prdt, m_pred(lk_pc, lk_br, lk_neg)); end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL same_cycle_new got %b want %b", prdt, m_pred(lk_pc, lk_br, lk_neg)); end
  endtask

  task automatic test_alias();
    lk_pc = 32'h100; lk_br = 1'b1; lk_neg = 1'b1;
    train(32'h200, 1'b0, 2);
    #1;
    checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL alias_nt got %b want %b", prdt, m_pred(lk_pc, lk_br, lk_neg)); end
    train(32'h200, 1'b1, 3);
    #1;
    checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL alias_t got %b want %b", prdt, m_pred(lk_pc, lk_br, lk_neg)); end
  endtask

  task automatic test_flush();
    int n = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b want 1", busy); end
    for (int i = 0; i < 30; i++) begin
      upd_valid = i[0]; upd_pc = 32'h100; upd_taken = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 200; c++) begin
      upd_valid = 1'b1; upd_pc = 32'h100 + 32'(($urandom & 3) << 2); upd_taken = 1'b1;
      #1;
      if (busy !== 1'b1) break;
      n++;
      tick();
    end
    upd_valid = 1'b0;
    checks++; if (n != DEPTH) begin errors++; $display("FAIL reflush_len got %0d want %0d", n, DEPTH); end
    checks++; if (dut.r_bht[0] !== 2'(mtab[0])) begin errors++; $display("FAIL flush_cnt0 got %0d want %0d", dut.r_bht[0], mtab[0]); end
    checks++; if (dut.r_bht[1] !== 2'(mtab[1])) begin errors++; $display("FAIL flush_cnt1 got %0d want %0d", dut.r_bht[1], mtab[1]); end
    checks++; if (dut.r_bht[63] !== 2'(mtab[63])) begin errors++; $display("FAIL flush_cnt63 got %0d want %0d", dut.r_bht[63], mtab[63]); end
  endtask

  task automatic test_stats();
    logic [1:0] pat [5] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = pat[i][1]; upd_prdt = pat[i][0];
      tick();
    end
    upd_valid = 1'b0;
    #1;
    checks++; if (br_cnt !== m_br) begin errors++; $display("FAIL stats_br got %0d want %0d", br_cnt, m_br); end
    checks++; if (mis_cnt !== m_mis) begin errors++; $display("FAIL stats_mis got %0d want %0d", mis_cnt, m_mis); end
  endtask

  task automatic test_sat();
    force dut.r_br_cnt = 32'hFFFF_FFFF;
    force dut.r_mis_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_br_cnt;
    release dut.r_mis_cnt;
    m_br = 32'hFFFF_FFFF;
    m_mis = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_prdt = 1'b0;
      tick();
    end
    upd_valid = 1'b0;
    #1;
    checks++; if (br_cnt !== m_br) begin errors++; $display("FAIL sat_br got %h want %h", br_cnt, m_br); end
    checks++; if (mis_cnt !== m_mis) begin errors++; $display("FAIL sat_mis got %h want %h", mis_cnt, m_mis); end
  endtask

  task automatic test_random();
    logic [PCW-1:0] pcs [4] = '{32'h100, 32'h104, 32'h200, 32'h1FC};
    for (int c = 0; c < 600; c++) begin
      rst_n     = (c != 0) && ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 79) == 0);
      lk_pc     = ($urandom_range(0, 3) == 0) ? PCW'($urandom) : pcs[$urandom_range(0, 3)];
      upd_pc    = ($urandom_range(0, 3) == 0) ? PCW'($urandom) : pcs[$urandom_range(0, 3)];
      lk_br     = ($urandom_range(0, 3) != 0);
      lk_neg    = 1'($urandom);
      upd_valid = 1'($urandom);
      upd_taken = 1'($urandom);
      upd_prdt  = 1'($urandom);
      #1;
      if (c > 0) begin
        checks++; if (prdt !== m_pred(lk_pc, lk_br, lk_neg)) begin errors++; $display("FAIL rnd_pred c=%0d got %b want %b", c, prdt, m_pred(lk_pc, lk_br, lk_neg)); end
        checks++; if (prdt_s !== (lk_br & lk_neg)) begin errors++; $display("FAIL rnd_static c=%0d got %b want %b", c, prdt_s, lk_br & lk_neg); end
        checks++; if (busy !== (busy_left > 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, busy_left > 0); end
        checks++; if (busy_s !== (busy_left > 0)) begin errors++; $display("FAIL rnd_busy_s c=%0d got %b want %b", c, busy_s, busy_left > 0); end
        checks++; if (br_cnt !== m_br || br_s !== m_br) begin errors++; $display("FAIL rnd_br c=%0d got %0d/%0d want %0d", c, br_cnt, br_s, m_br); end
        checks++; if (mis_cnt !== m_mis || mis_s !== m_mis) begin errors++; $display("FAIL rnd_mis c=%0d got %0d/%0d want %0d", c, mis_cnt, mis_s, m_mis); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mtab[i]) mtab[i] = 0;
    busy_left = DEPTH;
    m_br = '0;
    m_mis = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_dyn_basic();
    test_same_cycle();
    test_alias();
    test_flush();
    test_stats();
    test_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
